ll_fifo_scheduler: RTL and testbench

LL_FIFO_SCHEDULER -- requirements
Module: ll_fifo_scheduler

---
 rtl/ll_fifo_scheduler.sv | 149 ++++++++++++++
 tb/tb_ll_fifo_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_fifo_scheduler.sv
// Round-robin, credit-gated scheduler in front of a shared linked-list FIFO.
// Admits writes against a per-queue quota and drains into a one-beat output register.
module ll_fifo_scheduler #(
   parameter  int WIDTH     = 4,
   parameter  int DEPTH     = 4,
   parameter  int NUM_FIFOS = 2,
   parameter  int QUOTA     = DEPTH - 1,
   parameter  int CREDITS   = 2,
   localparam int SEL_W     = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
   localparam int CNT_W     = $clog2(QUOTA + 1) + 1,
   localparam int CRD_W     = (CREDITS > 0) ? $clog2(CREDITS + 1) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [SEL_W-1:0]     in_sel,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic                 push,
   output logic [SEL_W-1:0]     push_sel,
   output logic [WIDTH-1:0]     data_in,
   output logic                 pop,
   output logic [SEL_W-1:0]     pop_sel,
   input  logic                 full,
   input  logic [NUM_FIFOS-1:0] empty,
   input  logic [WIDTH-1:0]     data_out,
   input  logic [NUM_FIFOS-1:0] credit_ret,
   output logic                 out_valid,
   output logic [SEL_W-1:0]     out_sel,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready
);

   localparam logic [CNT_W-1:0] QUOTA_C   = CNT_W'(QUOTA);
   localparam logic [CRD_W-1:0] CREDITS_C = CRD_W'(CREDITS);
   localparam logic [SEL_W-1:0] LAST_Q    = SEL_W'(NUM_FIFOS - 1);
   localparam logic [SEL_W:0]   NUM_Q     = (SEL_W + 1)'(NUM_FIFOS);

   logic [CNT_W-1:0]     count_q  [NUM_FIFOS];
   logic [CNT_W-1:0]     count_d  [NUM_FIFOS];
   logic [CRD_W-1:0]     credit_q [NUM_FIFOS];
   logic [CRD_W-1:0]     credit_d [NUM_FIFOS];
   logic [SEL_W-1:0]     rr_q, rr_d;
   logic                 out_valid_q, out_valid_d;
   logic [SEL_W-1:0]     out_sel_q, out_sel_d;
   logic [WIDTH-1:0]     out_data_q, out_data_d;

   logic [NUM_FIFOS-1:0] elig;
   logic [NUM_FIFOS-1:0] push_vec, pop_vec;
   logic [SEL_W:0]       rr_idx;
   logic [SEL_W-1:0]     grant;
   logic                 any_elig;
   logic                 slot_free;

   // Write path is a zero-latency pass-through; admission gated by quota and storage full.
   assign in_ready = ~rst & ~full & (count_q[in_sel] < QUOTA_C);
   assign push     = in_valid & in_ready;
   assign push_sel = in_sel;
   assign data_in  = in_data;

   assign slot_free = ~out_valid_q | out_ready;
   assign pop       = ~rst & slot_free & any_elig;
   assign pop_sel   = pop ? grant : '0;

   always_comb begin
      for (int q = 0; q < NUM_FIFOS; q++) begin
         elig[q] = ~empty[q] & (credit_q[q] != '0);
      end
   end

   // Walk offsets from the top down so the smallest offset from rr_q wins.
   always_comb begin
      grant    = '0;
      any_elig = 1'b0;
      rr_idx   = '0;
      for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
         rr_idx = {1'b0, rr_q} + (SEL_W + 1)'(i);
         if (rr_idx >= NUM_Q) rr_idx = rr_idx - NUM_Q;
         if (elig[rr_idx[SEL_W-1:0]]) begin
            grant    = rr_idx[SEL_W-1:0];
            any_elig = 1'b1;
         end
      end
   end

   always_comb begin
      push_vec         = '0;
      pop_vec          = '0;
      push_vec[in_sel] = push;
      pop_vec[grant]   = pop;
   end

   always_comb begin
      for (int q = 0; q < NUM_FIFOS; q++) begin
         count_d[q] = count_q[q];
         if (push_vec[q] & ~pop_vec[q])      count_d[q] = count_q[q] + CNT_W'(1);
         else if (pop_vec[q] & ~push_vec[q]) count_d[q] = count_q[q] - CNT_W'(1);

         // A return that would overflow the downstream slot count is dropped.
         credit_d[q] = credit_q[q];
         if (credit_ret[q] & ~pop_vec[q] & (credit_q[q] != CREDITS_C))
            credit_d[q] = credit_q[q] + CRD_W'(1);
         else if (pop_vec[q] & ~credit_ret[q])
            credit_d[q] = credit_q[q] - CRD_W'(1);
      end
   end

   always_comb begin
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_sel_d   = out_sel_q;
      out_data_d  = out_data_q;
      if (pop) begin
         rr_d        = (grant == LAST_Q) ? '0 : grant + SEL_W'(1);
         out_valid_d = 1'b1;
         out_sel_d   = grant;
         out_data_d  = data_out;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int q = 0; q < NUM_FIFOS; q++) begin
            count_q[q]  <= '0;
            credit_q[q] <= CREDITS_C;
         end
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_sel_q   <= '0;
         out_data_q  <= '0;
      end else begin
         for (int q = 0; q < NUM_FIFOS; q++) begin
            count_q[q]  <= count_d[q];
            credit_q[q] <= credit_d[q];
         end
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_sel_q   <= out_sel_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_ll_fifo_scheduler.sv
// Directed bench for ll_fifo_scheduler with a behavioural two-queue shared FIFO model.
module tb_ll_fifo_scheduler;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_sel;
   logic [3:0] in_data;
   logic       in_ready;
   logic       push;
   logic       push_sel;
   logic [3:0] data_in;
   logic       pop;
   logic       pop_sel;
   logic       full;
   logic [1:0] empty;
   logic [3:0] data_out;
   logic [1:0] credit_ret;
   logic       out_valid;
   logic       out_sel;
   logic [3:0] out_data;
   logic       out_ready;

   ll_fifo_scheduler #(
      .WIDTH(4), .DEPTH(8), .NUM_FIFOS(2), .QUOTA(3), .CREDITS(2)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
      .push(push), .push_sel(push_sel), .data_in(data_in),
      .pop(pop), .pop_sel(pop_sel),
      .full(full), .empty(empty), .data_out(data_out),
      .credit_ret(credit_ret),
      .out_valid(out_valid), .out_sel(out_sel), .out_data(out_data),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared storage model: per-queue circular buffers, flags forceable by the bench.
   logic [3:0] mem [2][16];
   logic [3:0] wp [2];
   logic [3:0] rp [2];
   logic       mclr, pre_v, pre_q;
   logic [3:0] pre_d;
   logic       ffull;
   logic [1:0] fempty;
   logic [3:0] occ0, occ1;
   logic [1:0] cr_auto, cr_man;
   logic       auto_cr;

   assign occ0     = wp[0] - rp[0];
   assign occ1     = wp[1] - rp[1];
   assign empty    = fempty | {wp[1] == rp[1], wp[0] == rp[0]};
   assign full     = ffull | (({1'b0, occ0} + {1'b0, occ1}) >= 5'd8);
   assign data_out = mem[pop_sel][rp[pop_sel]];

   always @(posedge clk) begin
      if (mclr) begin
         wp[0] <= '0; wp[1] <= '0; rp[0] <= '0; rp[1] <= '0;
      end else begin
         if (pre_v) begin
            mem[pre_q][wp[pre_q]] <= pre_d;
            wp[pre_q] <= wp[pre_q] + 4'd1;
         end
         if (push) begin
            mem[push_sel][wp[push_sel]] <= data_in;
            wp[push_sel] <= wp[push_sel] + 4'd1;
         end
         if (pop) rp[pop_sel] <= rp[pop_sel] + 4'd1;
      end
   end

   // Downstream returns one slot the cycle after each accepted beat when enabled.
   always @(posedge clk)
      cr_auto <= (auto_cr && out_valid && out_ready) ? (out_sel ? 2'b10 : 2'b01) : 2'b00;
   assign credit_ret = cr_auto | cr_man;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       iv, sel;
      logic [3:0] d;
      logic       ff;
      logic [1:0] fe;
      logic       ordy;
      logic [1:0] cr;
      logic       e_ir, e_push, e_pop, e_psel, e_ov, e_osel;
      logic [3:0] e_od;
      logic [2:0] e_c0, e_c1;
   } vec_t;

   function automatic vec_t mk(input int iv, sel, d, ff, fe, ordy, cr,
                               ir, ps, pp, psl, ov, osl, od, c0, c1);
      vec_t v;
      v.iv = 1'(iv); v.sel = 1'(sel); v.d = 4'(d); v.ff = 1'(ff); v.fe = 2'(fe);
      v.ordy = 1'(ordy); v.cr = 2'(cr); v.e_ir = 1'(ir); v.e_push = 1'(ps);
      v.e_pop = 1'(pp); v.e_psel = 1'(psl); v.e_ov = 1'(ov); v.e_osel = 1'(osl);
      v.e_od = 4'(od); v.e_c0 = 3'(c0); v.e_c1 = 3'(c1);
      return v;
   endfunction

   vec_t vec [12];
   int   npop, got, first_c;

   task automatic push_word(input logic s, input logic [3:0] d);
      in_valid = 1'b1; in_sel = s; in_data = d;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //         iv sel d  ff fe rdy cr | ir ps pp psl ov osl od c0 c1
      vec[0]  = mk(1, 0, 1, 0, 3, 1, 0,   1, 1, 0, 0,  0, 0,  0, 1, 0);
      vec[1]  = mk(1, 0, 2, 0, 3, 1, 0,   1, 1, 0, 0,  0, 0,  0, 2, 0);
      vec[2]  = mk(1, 0, 3, 0, 3, 1, 0,   1, 1, 0, 0,  0, 0,  0, 3, 0);
      vec[3]  = mk(1, 0, 4, 0, 3, 1, 0,   0, 0, 0, 0,  0, 0,  0, 3, 0);
      vec[4]  = mk(1, 1, 5, 0, 3, 1, 0,   1, 1, 0, 0,  0, 0,  0, 3, 1);
      vec[5]  = mk(1, 1, 6, 1, 3, 1, 0,   0, 0, 0, 0,  0, 0,  0, 3, 1);
      vec[6]  = mk(0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0,  1, 0,  1, 2, 1);
      vec[7]  = mk(1, 1, 6, 0, 0, 1, 0,   1, 1, 1, 1,  1, 1,  5, 2, 1);
      vec[8]  = mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0,  1, 1,  5, 2, 1);
      vec[9]  = mk(0, 0, 0, 0, 0, 1, 2,   1, 0, 1, 0,  1, 0,  2, 1, 1);
      vec[10] = mk(0, 0, 0, 0, 0, 1, 2,   1, 0, 1, 1,  1, 1,  6, 1, 0);
      vec[11] = mk(0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0,  0, 0,  0, 1, 0);

      rst = 1'b1; mclr = 1'b1; pre_v = 1'b0; pre_q = 1'b0; pre_d = '0;
      in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out_ready = 1'b0;
      ffull = 1'b0; fempty = 2'b00; cr_man = 2'b00; auto_cr = 1'b0;

      // Reset: outputs forced low even with a poppable word and a pending write
      repeat (2) @(negedge clk);
      mclr = 1'b0; pre_v = 1'b1; pre_q = 1'b0; pre_d = 4'h7;
      @(negedge clk);
      pre_v = 1'b0; in_valid = 1'b1; in_sel = 1'b0; out_ready = 1'b1;
      #1;
      chk("rst in_ready", in_ready, 0);
      chk("rst push", push, 0);
      chk("rst pop", pop, 0);
      chk("rst pop_sel", pop_sel, 0);
      @(posedge clk); #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst out_sel", out_sel, 0);
      chk("rst out_data", out_data, 0);
      chk("rst credit0", dut.credit_q[0], 2);
      chk("rst credit1", dut.credit_q[1], 2);
      chk("rst rr", dut.rr_q, 0);
      chk("rst count0", dut.count_q[0], 0);
      @(negedge clk); mclr = 1'b1; in_valid = 1'b0;
      @(negedge clk); mclr = 1'b0; rst = 1'b0;

      // Table: quota, full, same-cycle push/pop, credit saturation/cancel, stall
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         in_valid = vec[i].iv; in_sel = vec[i].sel; in_data = vec[i].d;
         ffull = vec[i].ff; fempty = vec[i].fe; out_ready = vec[i].ordy; cr_man = vec[i].cr;
         #1;
         chk($sformatf("row%0d in_ready", i), in_ready, vec[i].e_ir);
         chk($sformatf("row%0d push", i), push, vec[i].e_push);
         chk($sformatf("row%0d push_sel", i), push_sel, vec[i].sel);
         chk($sformatf("row%0d data_in", i), data_in, vec[i].d);
         chk($sformatf("row%0d pop", i), pop, vec[i].e_pop);
         chk($sformatf("row%0d pop_sel", i), pop_sel, vec[i].e_psel);
         @(posedge clk); #1;
         chk($sformatf("row%0d out_valid", i), out_valid, vec[i].e_ov);
         if (vec[i].e_ov) begin
            chk($sformatf("row%0d out_sel", i), out_sel, vec[i].e_osel);
            chk($sformatf("row%0d out_data", i), out_data, vec[i].e_od);
         end
         chk($sformatf("row%0d count0", i), dut.count_q[0], vec[i].e_c0);
         chk($sformatf("row%0d count1", i), dut.count_q[1], vec[i].e_c1);
      end
      chk("tbl credit0", dut.credit_q[0], 0);
      chk("tbl credit1", dut.credit_q[1], 2);
      chk("tbl rr", dut.rr_q, 0);

      // Round-robin drain of three words per queue, one beat per cycle
      @(negedge clk);
      rst = 1'b1; mclr = 1'b1; in_valid = 1'b0; fempty = 2'b00; ffull = 1'b0; cr_man = 2'b00;
      @(negedge clk);
      rst = 1'b0; mclr = 1'b0; fempty = 2'b11; out_ready = 1'b1; auto_cr = 1'b1;
      for (int k = 0; k < 6; k++) push_word(k >= 3, (k < 3) ? 4'(k + 1) : 4'(k + 6));
      in_valid = 1'b0; fempty = 2'b00;
      got = 0; first_c = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            chk($sformatf("rr beat%0d sel", got), out_sel, got % 2);
            chk($sformatf("rr beat%0d data", got), out_data,
                (got % 2) ? 9 + got / 2 : 1 + got / 2);
            if (got == 0) first_c = c;
            else chk($sformatf("rr beat%0d cycle", got), c, first_c + got);
            got++;
         end
      end
      chk("rr beat count", got, 6);

      // Credit exhaustion: four words in q0, two credits, then one returned
      @(negedge clk);
      rst = 1'b1; mclr = 1'b1; auto_cr = 1'b0;
      @(negedge clk);
      mclr = 1'b0; pre_v = 1'b1; pre_q = 1'b0; pre_d = 4'hC;
      @(negedge clk);
      pre_v = 1'b0; rst = 1'b0; fempty = 2'b11;
      push_word(1'b0, 4'hD); push_word(1'b0, 4'hE); push_word(1'b0, 4'hF);
      in_valid = 1'b0; fempty = 2'b00; out_ready = 1'b1;
      npop = 0;
      for (int c = 0; c < 6; c++) begin
         #1; if (pop) npop++;
         @(negedge clk);
      end
      chk("credit pops", npop, 2);
      cr_man = 2'b01; #1;
      chk("pop in credit_ret cycle", pop, 0);
      @(negedge clk); cr_man = 2'b00; #1;
      chk("pop after credit_ret", pop, 1);
      chk("pop_sel after credit_ret", pop_sel, 0);
      npop = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); #1; if (pop) npop++;
      end
      chk("no further pops", npop, 0);

      // Output stall: beat holds while out_ready is low
      @(negedge clk);
      rst = 1'b1; mclr = 1'b1;
      @(negedge clk);
      rst = 1'b0; mclr = 1'b0; fempty = 2'b11; out_ready = 1'b0;
      push_word(1'b0, 4'h1); push_word(1'b0, 4'h2); push_word(1'b0, 4'h3);
      in_valid = 1'b0; fempty = 2'b00; #1;
      chk("stall first pop", pop, 1);
      @(posedge clk); #1;
      chk("stall out_valid", out_valid, 1);
      chk("stall out_data", out_data, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("stall%0d pop", c), pop, 0);
         chk($sformatf("stall%0d out_data", c), out_data, 1);
      end
      @(negedge clk); out_ready = 1'b1; #1;
      chk("release pop", pop, 1);
      @(posedge clk); #1;
      chk("release out_valid", out_valid, 1);
      chk("release out_data", out_data, 2);

      // Reset with a beat held in the output register
      @(negedge clk); out_ready = 1'b0; rst = 1'b1; in_valid = 1'b1; #1;
      chk("midrst in_ready", in_ready, 0);
      chk("midrst push", push, 0);
      @(posedge clk); #1;
      chk("midrst out_valid", out_valid, 0);
      chk("midrst credit0", dut.credit_q[0], 2);
      chk("midrst credit1", dut.credit_q[1], 2);
      chk("midrst rr", dut.rr_q, 0);
      @(negedge clk); rst = 1'b0; in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
